macroblock_encode_cbp: RTL and testbench
========================================

Name: macroblock_encode_cbp

Overview:
- Bit-serial variable-length encoder for coded_block_pattern (Table B.9 codes, 3 to 9 bits) in the macroblock layer of the encoder path.
- Accepts one 6-bit CBP symbol and looks up its codeword and length in the shared coefficient/VLC table memory.
- Emits the codeword MSB-first, one bit per handshake, into the downstream bitstream packer.
- Mirror of the bit-serial CBP decoder; uses the same table memory port style.

Parameters:
- TABLE_OFFSET, 10'd0: base address of the 64-entry CBP encode table in the table memory. Entry address is TABLE_OFFSET + symbol.
- MAX_LEN, 9: largest legal code length.
- MIN_LEN, 3: smallest legal code length.

Ports:
- resetn, input, 1: reset, asynchronous, active-low.
- clock, input, 1: clock.
- Start_I, input, 1: request to encode Symbol_I. Sampled only when Busy_O=0.
- Symbol_I, input, 6: CBP value. Latched on an accepted Start_I.
- Busy_O, output, 1: high from the cycle after an accepted Start_I until the return to IDLE.
- Table_En_O, output, 1: table memory read enable.
- Table_Addr_O, output, 10: table memory address.
- Table_Data_I, input, 16: table read data, valid 1 cycle after the enable. Format: [15:12] = length, [11:9] = reserved, [8:0] = code, right-aligned.
- Bit_O, output, 1: current code bit. Forced to 0 when Bit_Valid_O=0.
- Bit_Valid_O, output, 1: Bit_O is valid.
- Bit_Ready_I, input, 1: downstream accepts the bit. A transfer occurs when Bit_Valid_O & Bit_Ready_I.
- Done_O, output, 1: one-cycle pulse after the last bit is transferred.
- Error_O, output, 1: one-cycle pulse when the fetched length is illegal.

Behaviour:
- Reset values: all outputs 0; state IDLE; symbol, code and length registers cleared.
- Asserting resetn mid-operation aborts immediately. No Done_O and no Error_O are produced.
- State IDLE: Busy_O=0.
  - Start_I=1 latches Symbol_I and moves to FETCH.
  - Start_I while Busy_O=1 is ignored and has no side effects.
- State FETCH (1 cycle): Table_En_O=1, Table_Addr_O = TABLE_OFFSET + {4'b0, symbol}.
  - The address is 10-bit modulo; overflow wraps.
  - Next state: LOAD.
- State LOAD (1 cycle): latch len = Table_Data_I[15:12] and code = Table_Data_I[8:0].
  - If len < MIN_LEN or len > MAX_LEN: pulse Error_O, go to IDLE, emit no bits.
  - Otherwise: set bit counter cnt = len-1 and go to SHIFT.
  - Table_En_O=0 in every state except FETCH.
- State SHIFT: Bit_Valid_O=1, Bit_O = code[cnt].
  - On a transfer with cnt>0: decrement cnt.
  - On a transfer with cnt==0: go to DONE.
  - Bit_Ready_I=0 holds Bit_O and cnt stable for any number of cycles.
- State DONE (1 cycle): Done_O=1, Busy_O=1. Next state: IDLE.
- Start_I is accepted in the first IDLE cycle after DONE. Back-to-back minimum period is len+4 cycles.
- Latency with Bit_Ready_I held at 1:
  - Start_I accepted at edge 0.
  - FETCH in cycle 1, LOAD in cycle 2, first bit in cycle 3.
  - Last bit in cycle 2+len; Done_O in cycle 3+len.
- Bits of code above len-1 are ignored.
- The reserved bits of Table_Data_I are ignored.

Test Plan:
- Symbol 60, table entry 16'h3007 (len 3, code 111), Bit_Ready_I=1 -> Table_Addr_O=60 in cycle 1; bits 1,1,1 in cycles 3-5; Done_O in cycle 6; Busy_O low in cycle 7.
- Symbol 4, entry 16'h400D (len 4, code 1101), Bit_Ready_I low on alternate cycles -> bits 1,1,0,1, each held until accepted; exactly 4 transfers; then Done_O.
- Symbol 0, entry 16'h9001 (len 9, code 0000_0000_1) -> 8 zeros then 1; Done_O 12 cycles after Start_I; TABLE_OFFSET=10'h3F0 gives Table_Addr_O=10'h3F0.
- Entry 16'hA000 (len 10) and entry 16'h2003 (len 2) -> Error_O pulse in the LOAD cycle; Bit_Valid_O never asserted; back to IDLE.
- Start_I held high continuously with symbols changing every cycle -> only the symbol present at each IDLE acceptance is encoded; the next encode starts one IDLE cycle after Done_O.
- resetn low during SHIFT after 2 of 5 bits -> all outputs 0 immediately; after release the next Start_I encodes correctly from its first bit.

Source files
------------

// File: rtl/macroblock_encode_cbp_if.sv
// Request, table-memory and serial-bit signals of the CBP encoder.
// slave: encoder side; master: environment side.
interface macroblock_encode_cbp_if;
    logic        Start_I;
    logic [5:0]  Symbol_I;
    logic        Busy_O;
    logic        Table_En_O;
    logic [9:0]  Table_Addr_O;
    logic [15:0] Table_Data_I;
    logic        Bit_O;
    logic        Bit_Valid_O;
    logic        Bit_Ready_I;
    logic        Done_O;
    logic        Error_O;

    modport slave (
        input  Start_I,
        input  Symbol_I,
        input  Table_Data_I,
        input  Bit_Ready_I,
        output Busy_O,
        output Table_En_O,
        output Table_Addr_O,
        output Bit_O,
        output Bit_Valid_O,
        output Done_O,
        output Error_O
    );

    modport master (
        output Start_I,
        output Symbol_I,
        output Table_Data_I,
        output Bit_Ready_I,
        input  Busy_O,
        input  Table_En_O,
        input  Table_Addr_O,
        input  Bit_O,
        input  Bit_Valid_O,
        input  Done_O,
        input  Error_O
    );
endinterface

// File: rtl/macroblock_encode_cbp.sv
// Bit-serial coded_block_pattern VLC encoder.
// Looks up {len, code} in table memory, emits code MSB-first.
module macroblock_encode_cbp #(
    parameter logic [9:0] TABLE_OFFSET = 10'd0,
    parameter int         MAX_LEN      = 9,
    parameter int         MIN_LEN      = 3
) (
    input logic             resetn,
    input logic             clock,
    macroblock_encode_cbp_if.slave cbp
);

    localparam logic [3:0] MAX_L = 4'(MAX_LEN);
    localparam logic [3:0] MIN_L = 4'(MIN_LEN);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] symbol_q;
    logic [8:0] code_q;
    logic [3:0] len_q;
    logic [3:0] cnt_q;

    logic [3:0] t_len;
    logic [8:0] t_code;
    logic       len_bad;
    logic       xfer;
    logic       last_bit;
    logic       unused_rsvd;

    assign t_len       = cbp.Table_Data_I[15:12];
    assign t_code      = cbp.Table_Data_I[8:0];
    assign unused_rsvd = ^cbp.Table_Data_I[11:9];
    assign len_bad     = (t_len < MIN_L) || (t_len > MAX_L);
    assign xfer        = (state_q == SHIFT) && cbp.Bit_Ready_I;
    assign last_bit    = (cnt_q == 4'd0);

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cbp.Start_I) state_d = FETCH;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                state_d = len_bad ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (xfer && last_bit) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Symbol, code, length and bit counter
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            symbol_q <= '0;
            code_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (state_q == IDLE && cbp.Start_I) begin
                symbol_q <= cbp.Symbol_I;
            end
            if (state_q == LOAD) begin
                len_q  <= t_len;
                code_q <= t_code;
                if (!len_bad) cnt_q <= t_len - 4'd1;
            end
            if (xfer && !last_bit) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Output logic
    always_comb begin
        cbp.Busy_O       = 1'b0;
        cbp.Table_En_O   = 1'b0;
        cbp.Table_Addr_O = '0;
        cbp.Bit_O        = 1'b0;
        cbp.Bit_Valid_O  = 1'b0;
        cbp.Done_O       = 1'b0;
        cbp.Error_O      = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            FETCH: begin
                cbp.Busy_O       = 1'b1;
                cbp.Table_En_O   = 1'b1;
                cbp.Table_Addr_O = TABLE_OFFSET + {4'b0, symbol_q};
            end
            LOAD: begin
                cbp.Busy_O  = 1'b1;
                cbp.Error_O = len_bad;
            end
            SHIFT: begin
                cbp.Busy_O      = 1'b1;
                cbp.Bit_Valid_O = 1'b1;
                // cnt never reaches len, so code bits above len-1 stay unused
                cbp.Bit_O       = code_q[cnt_q] & (cnt_q < len_q);
            end
            DONE: begin
                cbp.Busy_O = 1'b1;
                cbp.Done_O = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_macroblock_encode_cbp.sv
// Scoreboard bench for the CBP encoder with a table-memory model.
// Random symbols, table contents and downstream backpressure.
module tb_macroblock_encode_cbp;

    localparam logic [9:0] OFFS = 10'h3F0;

    logic clock = 1'b0;
    logic resetn = 1'b0;

    macroblock_encode_cbp_if bus ();

    macroblock_encode_cbp #(
        .TABLE_OFFSET(OFFS),
        .MAX_LEN(9),
        .MIN_LEN(3)
    ) dut (
        .resetn(resetn),
        .clock(clock),
        .cbp(bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] addr;
        bit         err;
        int         len;
        logic [8:0] code;
        bit         full;
        bit         b2b;
        int         acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] tmem[1024];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          mon_idx = 0;
    int          last_end = 0;
    bit          idle_chk = 0;
    int          ready_mode = 0;

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Table memory: data valid one cycle after enable, junk otherwise
    initial begin
        bus.Table_Data_I = '0;
        forever begin
            @(posedge clock);
            bus.Table_Data_I <= bus.Table_En_O ?
                tmem[bus.Table_Addr_O] : 16'($urandom);
        end
    end

    // Downstream readiness
    initial begin
        bus.Bit_Ready_I = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: bus.Bit_Ready_I = 1'b1;
                1: bus.Bit_Ready_I = 1'($urandom);
                default: bus.Bit_Ready_I = ~bus.Bit_Ready_I;
            endcase
        end
    end

    // Reference model: a symbol maps to its table word, length and code
    function automatic exp_t model(input logic [5:0] sym, input bit b2b);
        exp_t        x;
        logic [15:0] w;
        x.addr = 10'((int'(OFFS) + int'(sym)) % 1024);
        w      = tmem[x.addr];
        x.len  = int'(w[15:12]);
        x.err  = (x.len < 3) || (x.len > 9);
        x.code = w[8:0];
        x.full = (ready_mode == 0);
        x.b2b  = b2b;
        x.acc  = cyc;
        return x;
    endfunction

    // Monitor: compares DUT activity with the scoreboard head
    always @(negedge clock) begin
        if (!resetn) begin
            sb.delete();
            mon_idx  = 0;
            idle_chk = 0;
        end else begin
            if (idle_chk) begin
                chk(!bus.Busy_O, "busy_after_end", bus.Busy_O, 0);
                idle_chk = 0;
            end
            if (!bus.Bit_Valid_O) begin
                chk(!bus.Bit_O, "bit_zero_idle", bus.Bit_O, 0);
            end
            if (bus.Table_En_O) begin
                chk(sb.size() != 0, "fetch_unexpected", 1, 0);
                if (sb.size() != 0) begin
                    e = sb[0];
                    chk(bus.Table_Addr_O == e.addr, "table_addr",
                        bus.Table_Addr_O, e.addr);
                    chk(cyc == e.acc + 1, "fetch_cycle", cyc, e.acc + 1);
                    if (e.b2b)
                        chk(cyc == last_end + 2, "b2b_restart",
                            cyc, last_end + 2);
                end
            end
            if (bus.Bit_Valid_O && bus.Bit_Ready_I) begin
                chk(sb.size() != 0, "bit_unexpected", 1, 0);
                if (sb.size() != 0) begin
                    e = sb[0];
                    chk(!e.err && mon_idx < e.len, "bit_count",
                        mon_idx + 1, e.err ? 0 : e.len);
                    if (!e.err && mon_idx < e.len)
                        chk(bus.Bit_O == ((e.code >> (e.len - 1 - mon_idx)) & 1),
                            "bit_value", bus.Bit_O,
                            (e.code >> (e.len - 1 - mon_idx)) & 1);
                    mon_idx++;
                end
            end
            if (bus.Error_O) begin
                chk(sb.size() != 0, "error_unexpected", 1, 0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk(e.err, "error_len", e.len, 0);
                    chk(mon_idx == 0, "error_bits", mon_idx, 0);
                    chk(cyc == e.acc + 2, "error_cycle", cyc, e.acc + 2);
                    mon_idx  = 0;
                    last_end = cyc;
                    idle_chk = 1;
                end
            end
            if (bus.Done_O) begin
                chk(sb.size() != 0, "done_unexpected", 1, 0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk(!e.err, "done_on_bad_len", e.len, 0);
                    chk(mon_idx == e.len, "done_bits", mon_idx, e.len);
                    chk(bus.Busy_O, "busy_in_done", bus.Busy_O, 1);
                    if (e.full)
                        chk(cyc == e.acc + 3 + e.len, "done_cycle",
                            cyc, e.acc + 3 + e.len);
                    mon_idx  = 0;
                    last_end = cyc;
                    idle_chk = 1;
                end
            end
        end
    end

    task automatic outs_zero(input string name);
        logic [15:0] v;
        v = {bus.Busy_O, bus.Table_En_O, bus.Table_Addr_O,
             bus.Bit_O, bus.Bit_Valid_O, bus.Done_O, bus.Error_O};
        chk(v == 0, name, v, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic start_enc(input logic [5:0] sym);
        bit ok;
        ok = 0;
        bus.Start_I  = 1'b1;
        bus.Symbol_I = sym;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!bus.Busy_O) begin
                ok = 1;
                sb.push_back(model(sym, 0));
                break;
            end
            @(posedge clock);
            #1;
        end
        chk(ok, "start_accept", ok, 1);
        @(posedge clock);
        #1;
        bus.Start_I  = 1'b0;
        bus.Symbol_I = 6'($urandom);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(ok, "done_timeout", sb.size(), 0);
        if (!ok) sb.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit started;
        for (int a = 0; a < 1024; a++) begin
            logic [3:0] l;
            if ($urandom_range(0, 9) == 0)
                l = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 2));
            else
                l = 4'($urandom_range(3, 9));
            tmem[a] = {l, 3'($urandom), 9'($urandom)};
        end
        tmem[10'(OFFS + 10'd60)] = 16'h3007;
        tmem[10'(OFFS + 10'd4)]  = 16'h400D;
        tmem[10'(OFFS + 10'd0)]  = 16'h9001;
        tmem[10'(OFFS + 10'd1)]  = 16'hA000;
        tmem[10'(OFFS + 10'd2)]  = 16'h2003;
        tmem[10'(OFFS + 10'd5)]  = 16'h5015;

        bus.Start_I  = 1'b0;
        bus.Symbol_I = '0;
        resetn       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        outs_zero("reset_outputs");
        bus.Start_I = 1'b1;
        #1;
        outs_zero("reset_start_ignored");
        bus.Start_I = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        outs_zero("idle_outputs");

        ready_mode = 0;
        start_enc(6'd60);
        wait_done();
        start_enc(6'd0);
        wait_done();
        ready_mode = 2;
        start_enc(6'd4);
        wait_done();
        ready_mode = 0;
        start_enc(6'd1);
        wait_done();
        start_enc(6'd2);
        wait_done();

        start_enc(6'd5);
        repeat (4) @(posedge clock);
        #1;
        chk(mon_idx == 2, "bits_before_reset", mon_idx, 2);
        resetn = 1'b0;
        #1;
        outs_zero("mid_reset_outputs");
        @(negedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        start_enc(6'd5);
        wait_done();

        for (int n = 0; n < 60; n++) begin
            ready_mode = $urandom_range(0, 1);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            start_enc(6'($urandom));
            wait_done();
        end

        ready_mode = 1;
        started    = 0;
        bus.Start_I = 1'b1;
        for (int n = 0; n < 120; n++) begin
            bus.Symbol_I = 6'($urandom);
            @(negedge clock);
            if (!bus.Busy_O) begin
                sb.push_back(model(bus.Symbol_I, started));
                started = 1;
            end
            @(posedge clock);
            #1;
        end
        bus.Start_I = 1'b0;
        wait_done();
        repeat (3) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
